// File: rtl/exp_chain_ctrl.sv
// Sequencer for a linear chain of pe_exp stages evaluating exp(x) by Taylor series.
// Drives the chain head seeds, the shared advance enable and per-stage factorial constants.
module exp_chain_ctrl #(
    parameter int N_TERMS = 8,
    parameter int CNT_W   = $clog2(N_TERMS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  real              in_x,
    output logic             out_valid,
    input  logic             out_ready,
    output real              out_result,
    output logic             pe_do_process,
    output logic             pe_clear,
    output real              head_x,
    output real              head_x_pow,
    output real              head_taylor,
    output real              k_factorial [N_TERMS],
    input  real              tail_taylor,
    output logic [CNT_W-1:0] in_flight,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } state_e;

    function automatic real fact_f(input int n);
        real acc;
        acc = 1.0;
        for (int j = 2; j <= n; j++) begin
            acc = acc * real'(j);
        end
        return acc;
    endfunction

    logic [N_TERMS-1:0] vld_q, vld_d;
    logic [CNT_W-1:0]   in_flight_q, in_flight_d;
    state_e             state_q, state_d;
    logic               advance_s, clear_s, accept_s, pop_s;

    // A full tail that downstream refuses freezes the whole chain.
    assign advance_s     = !(vld_q[N_TERMS-1] && !out_ready);
    assign clear_s       = reset || flush;
    assign in_ready      = advance_s && !flush && !reset;
    assign accept_s      = in_valid && in_ready;
    assign out_valid     = vld_q[N_TERMS-1] && !clear_s;
    assign pop_s         = out_valid && out_ready;
    assign out_result    = tail_taylor;
    assign pe_do_process = advance_s;
    assign pe_clear      = clear_s;
    assign head_x        = in_valid ? in_x : 0.0;
    assign head_x_pow    = 1.0;
    assign head_taylor   = 1.0;
    assign in_flight     = in_flight_q;
    assign state         = state_q;

    // Stage i contributes x^(i+1)/(i+1)!.
    always_comb begin
        for (int i = 0; i < N_TERMS; i++) begin
            k_factorial[i] = fact_f(i + 1);
        end
    end

    // Occupancy shift register and in-flight counter next state.
    always_comb begin
        vld_d       = vld_q;
        in_flight_d = in_flight_q;
        if (clear_s) begin
            vld_d       = {N_TERMS{1'b0}};
            in_flight_d = {CNT_W{1'b0}};
        end else if (advance_s) begin
            vld_d       = (vld_q << 1) | N_TERMS'(accept_s);
            in_flight_d = in_flight_q + CNT_W'(accept_s) - CNT_W'(pop_s);
        end else begin
            vld_d       = vld_q;
            in_flight_d = in_flight_q;
        end
    end

    // Status state: stall dominates, idle once nothing remains in flight.
    always_comb begin
        state_d = state_q;
        if (clear_s) begin
            state_d = ST_IDLE;
        end else if (vld_q[N_TERMS-1] && !out_ready) begin
            state_d = ST_STALL;
        end else if (in_flight_d == {CNT_W{1'b0}}) begin
            state_d = ST_IDLE;
        end else begin
            state_d = ST_RUN;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q       <= {N_TERMS{1'b0}};
            in_flight_q <= {CNT_W{1'b0}};
            state_q     <= ST_IDLE;
        end else begin
            vld_q       <= vld_d;
            in_flight_q <= in_flight_d;
            state_q     <= state_d;
        end
    end

endmodule

// File: tb/tb_exp_chain_ctrl.sv
// Scoreboard bench for exp_chain_ctrl with a behavioural pe_exp chain attached.
module tb_exp_chain_ctrl;

    localparam int N     = 8;
    localparam int CNT_W = $clog2(N + 1);

    logic             clk;
    logic             reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic             pe_do_process, pe_clear;
    real              in_x, out_result, head_x, head_x_pow, head_taylor, tail_taylor;
    real              k_fact [N];
    logic [CNT_W-1:0] in_flight;
    logic [1:0]       state;

    real st_x [N];
    real st_pow [N];
    real st_tay [N];

    int  n_tests, n_fail, cyc_cnt, pop_cnt, pops0, ov_cnt, acc_c;
    bit  lat_chk;
    real sb[$];
    int  acc_q[$];
    real exp_v, held;
    real kf_exp [N] = '{1.0, 2.0, 6.0, 24.0, 120.0, 720.0, 5040.0, 40320.0};

    exp_chain_ctrl #(.N_TERMS(N)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .pe_do_process(pe_do_process), .pe_clear(pe_clear),
        .head_x(head_x), .head_x_pow(head_x_pow), .head_taylor(head_taylor),
        .k_factorial(k_fact), .tail_taylor(tail_taylor),
        .in_flight(in_flight), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Behavioural pe_exp chain
    always @(posedge clk) begin
        if (pe_clear) begin
            for (int i = 0; i < N; i++) begin
                st_x[i] <= 0.0; st_pow[i] <= 0.0; st_tay[i] <= 0.0;
            end
        end else if (pe_do_process) begin
            st_x[0]   <= head_x;
            st_pow[0] <= head_x_pow * head_x;
            st_tay[0] <= head_taylor + head_x_pow * head_x / k_fact[0];
            for (int i = 1; i < N; i++) begin
                st_x[i]   <= st_x[i-1];
                st_pow[i] <= st_pow[i-1] * st_x[i-1];
                st_tay[i] <= st_tay[i-1] + st_pow[i-1] * st_x[i-1] / k_fact[i];
            end
        end
    end
    assign tail_taylor = st_tay[N-1];

    function automatic real model_exp(input real x);
        real term, sum;
        term = 1.0;
        sum  = 1.0;
        for (int k = 1; k <= N; k++) begin
            term = term * x / real'(k);
            sum  = sum + term;
        end
        return sum;
    endfunction

    task automatic check_result(input string tag, input real got, input real expv);
        real d;
        n_tests++;
        d = got - expv;
        if (d < 0.0) d = -d;
        if (d > 1.0e-8) begin
            n_fail++;
            $display("FAIL %s: got %0.9f expected %0.9f", tag, got, expv);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input real x);
        in_valid = 1'b1;
        in_x     = x;
        next_cycle();
    endtask

    // Scoreboard: push on accept, pop and compare on output handshake
    always @(negedge clk) begin
        if (reset || flush) begin
            sb.delete();
            acc_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                pop_cnt++;
                if (sb.size() == 0) begin
                    check_result("spurious_out", real'(sb.size()), 1.0);
                end else begin
                    exp_v = sb.pop_front();
                    acc_c = acc_q.pop_front();
                    check_result("result", out_result, exp_v);
                    if (lat_chk) check_result("latency", real'(cyc_cnt - acc_c), real'(N));
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(model_exp(in_x));
                acc_q.push_back(cyc_cnt);
            end
        end
    end

    initial begin
        n_tests = 0; n_fail = 0; cyc_cnt = 0; pop_cnt = 0; lat_chk = 1'b0;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_x = 0.0; out_ready = 1'b1;
        repeat (2) next_cycle();
        @(negedge clk);
        check_result("rst_out_valid", real'(out_valid), 0.0);
        check_result("rst_pe_clear", real'(pe_clear), 1.0);
        check_result("rst_in_flight", real'(in_flight), 0.0);
        check_result("rst_state", real'(state), 0.0);
        check_result("rst_in_ready", real'(in_ready), 0.0);
        next_cycle();
        reset = 1'b0;

        // single operand
        lat_chk = 1'b1;
        pops0 = pop_cnt;
        in_valid = 1'b1; in_x = 1.0;
        @(negedge clk);
        check_result("t1_in_ready", real'(in_ready), 1.0);
        check_result("t1_model", model_exp(1.0), 2.71827877);
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        check_result("t1_in_flight", real'(in_flight), 1.0);
        check_result("t1_state_run", real'(state), 1.0);
        repeat (N + 2) next_cycle();
        @(negedge clk);
        check_result("t1_in_flight0", real'(in_flight), 0.0);
        check_result("t1_state_idle", real'(state), 0.0);
        check_result("t1_pops", real'(pop_cnt - pops0), 1.0);

        // back-to-back operands
        pops0 = pop_cnt;
        send(0.0); send(1.0); send(2.0); send(-1.0);
        in_valid = 1'b0;
        repeat (N + 3) next_cycle();
        check_result("t2_pops", real'(pop_cnt - pops0), 4.0);
        check_result("t2_sb_empty", real'(sb.size()), 0.0);

        // backpressure with a full chain
        lat_chk = 1'b0;
        pops0 = pop_cnt;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) send(0.25 * real'(i) - 1.0);
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) begin
                held = out_result;
                check_result("t3_in_flight", real'(in_flight), real'(N));
                check_result("t3_pe_do", real'(pe_do_process), 0.0);
                check_result("t3_in_ready", real'(in_ready), 0.0);
                check_result("t3_out_valid", real'(out_valid), 1.0);
            end else begin
                check_result("t3_state_stall", real'(state), 2.0);
                check_result("t3_hold", out_result, held);
            end
            next_cycle();
        end
        check_result("t3_no_pop", real'(pop_cnt - pops0), 0.0);
        out_ready = 1'b1;
        repeat (N + 2) next_cycle();
        check_result("t3_pops", real'(pop_cnt - pops0), real'(N));
        check_result("t3_sb_empty", real'(sb.size()), 0.0);

        // simultaneous accept and pop
        lat_chk = 1'b1;
        pops0 = pop_cnt;
        for (int i = 0; i < 2 * N; i++) begin
            in_valid = 1'b1;
            in_x = 0.125 * real'(i) - 0.9;
            @(negedge clk);
            if (i >= N) check_result("t4_in_flight", real'(in_flight), real'(N));
            next_cycle();
        end
        in_valid = 1'b0;
        repeat (N + 2) next_cycle();
        check_result("t4_pops", real'(pop_cnt - pops0), real'(2 * N));

        // flush with 3 in flight
        lat_chk = 1'b0;
        pops0 = pop_cnt;
        send(0.3); send(0.6); send(0.9);
        in_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        check_result("t5_pe_clear", real'(pe_clear), 1.0);
        check_result("t5_in_ready", real'(in_ready), 0.0);
        check_result("t5_in_flight3", real'(in_flight), 3.0);
        next_cycle();
        flush = 1'b0;
        @(negedge clk);
        check_result("t5_pe_clear_off", real'(pe_clear), 0.0);
        check_result("t5_in_flight0", real'(in_flight), 0.0);
        check_result("t5_state_idle", real'(state), 0.0);
        ov_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            @(negedge clk);
            if (out_valid) ov_cnt++;
        end
        check_result("t5_no_out_valid", real'(ov_cnt), 0.0);
        next_cycle();
        lat_chk = 1'b1;
        send(0.5);
        in_valid = 1'b0;
        repeat (N + 2) next_cycle();
        check_result("t5_pops", real'(pop_cnt - pops0), 1.0);

        // reset mid-stream with 5 in flight
        lat_chk = 1'b0;
        pops0 = pop_cnt;
        for (int i = 0; i < 5; i++) send(real'(i) * 0.2);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check_result("t6_pe_clear", real'(pe_clear), 1.0);
        check_result("t6_out_valid", real'(out_valid), 0.0);
        check_result("t6_in_ready", real'(in_ready), 0.0);
        next_cycle();
        @(negedge clk);
        check_result("t6_in_flight", real'(in_flight), 0.0);
        check_result("t6_state", real'(state), 0.0);
        next_cycle();
        reset = 1'b0;
        ov_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid) ov_cnt++;
            next_cycle();
        end
        check_result("t6_no_stale", real'(ov_cnt), 0.0);
        check_result("t6_pops", real'(pop_cnt - pops0), 0.0);
        for (int i = 0; i < N; i++) check_result($sformatf("k_fact%0d", i), k_fact[i], kf_exp[i]);

        check_result("final_sb_empty", real'(sb.size()), 0.0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
